// File: rtl/cacheline_adaptor.sv
`timescale 1ns/1ps
// cacheline_adaptor: splits 256-bit line writes into four 64-bit beats and
// assembles four 64-bit read beats into a line; one transaction at a time.
// Ports:
//   clk, rst                  clock, async active-high reset
//   line_i, address_i         write line and line address from write buffer
//   read_i, write_i, resp_o   line request strobes and completion pulse
//   line_o                    assembled read line
//   burst_i, burst_o          64-bit read / write beats on memory bus
//   address_o                 aligned burst address (0 while idle)
//   read_o, write_o, resp_i   burst requests and per-beat memory strobe
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic [26:0]  addr_q, addr_d;
  logic [255:0] rbuf_q, rbuf_d;
  logic [255:0] wbuf_q, wbuf_d;
  logic [7:0]   bsel;

  // Line offset bits are dropped: bursts are always line aligned.
  logic unused_offset;
  assign unused_offset = ^address_i[4:0];

  assign bsel = {beat_q, 6'd0};

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    rbuf_d  = rbuf_q;
    wbuf_d  = wbuf_q;
    unique case (state_q)
      IDLE: begin
        // Write has priority when both are requested.
        if (write_i) begin
          addr_d  = address_i[31:5];
          wbuf_d  = line_i;
          beat_d  = 2'd0;
          state_d = WR;
        end else if (read_i) begin
          addr_d  = address_i[31:5];
          beat_d  = 2'd0;
          state_d = RD;
        end
      end
      RD: begin
        if (resp_i) begin
          rbuf_d[bsel +: 64] = burst_i;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = DONE;
        end
      end
      WR: begin
        if (resp_i) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = DONE;
        end
      end
      DONE: begin
        // Requests deliberately not sampled here.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      addr_q  <= 27'd0;
      rbuf_q  <= 256'd0;
      wbuf_q  <= 256'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      rbuf_q  <= rbuf_d;
      wbuf_q  <= wbuf_d;
    end
  end

  assign read_o    = (state_q == RD);
  assign write_o   = (state_q == WR);
  assign resp_o    = (state_q == DONE);
  assign line_o    = rbuf_q;
  assign address_o = (state_q == IDLE) ? 32'd0 : {addr_q, 5'd0};
  assign burst_o   = (state_q == WR) ? wbuf_q[bsel +: 64] : 64'd0;

endmodule
